// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator datapath constants and types
package calc_pkg;

  localparam int CALC_WIDTH  = 16;
  localparam int CALC_DIGITS = 5;
  localparam int DIGIT_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction (add 3 when digit >= 5)
module bcd_add3 (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // A digit is at most 9 here, so the corrected value always fits in 4 bits.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) digit_out = digit_in + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH  = CALC_WIDTH,
  parameter int DIGITS = CALC_DIGITS
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        START,
  input  logic [WIDTH-1:0]            BIN,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [DIGIT_W*DIGITS-1:0]   BCD
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_nxt;
  logic               start_prev;
  logic               accept;
  logic [WIDTH-1:0]   shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BCD_W-1:0]   bcd_q;
  logic               done_q;

  assign accept = START & ~start_prev;
  assign BUSY   = (state != IDLE);
  assign DONE   = done_q;
  assign BCD    = bcd_q;

  // Every scratch digit is corrected in parallel before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (scratch[g*DIGIT_W +: DIGIT_W]),
      .digit_out (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one accepted edge starts WIDTH shifts, then one finish cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: edge history, operand capture, shifting and result publish.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_prev <= 1'b0;
      shift_reg  <= '0;
      scratch    <= '0;
      bit_cnt    <= '0;
      bcd_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      start_prev <= START;
      done_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= BIN;
            scratch   <= '0;
            bit_cnt   <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          scratch   <= {scratch_adj[BCD_W-2:0], shift_reg[WIDTH-1]};
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt - CNT_W'(1);
        end
        FINISH: begin
          bcd_q  <= scratch;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [15:0] BIN;
  logic        BUSY;
  logic        DONE;
  logic [19:0] BCD;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_seq dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .BCD   (BCD)
  );

  always #5 CLK = ~CLK;

  // Decimal digits by repeated division, packed one digit per nibble.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Pulse START for one cycle and wait for DONE; lat counts negedges after the accepting edge.
  task automatic run_one(input logic [15:0] v, output int lat, output int busy_n,
                         output logic [19:0] bcd_mid, output bit timed_out);
    @(negedge CLK);
    BIN   = v;
    START = 1'b1;
    @(negedge CLK);
    START     = 1'b0;
    lat       = 0;
    busy_n    = 0;
    timed_out = 1'b0;
    bcd_mid   = BCD;
    while (!DONE && !timed_out) begin
      if (BUSY) busy_n++;
      if (lat == 8) bcd_mid = BCD;
      @(negedge CLK);
      lat++;
      if (lat > 40) timed_out = 1'b1;
    end
  endtask

  task automatic test_reset();
    int n;
    RST_N = 1'b0;
    START = 1'b1;
    BIN   = 16'd77;
    #12;
    total++; if (BCD !== 20'h0)  begin bad++; $display("FAIL reset_bcd got=%h want=%h", BCD, 20'h0); end
    total++; if (BUSY !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    total++; if (DONE !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", DONE); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL start_high_after_reset got=%b want=1", BUSY); end
    START = 1'b0;
    n = 0;
    while (!DONE && n < 40) begin @(negedge CLK); n++; end
    total++; if (n != 17) begin bad++; $display("FAIL reset_first_latency got=%0d want=17", n); end
    total++; if (BCD !== ref_bcd(77)) begin bad++; $display("FAIL reset_first_bcd got=%h want=%h", BCD, ref_bcd(77)); end
  endtask

  task automatic test_fixed();
    logic [15:0] vals [4];
    logic [19:0] exps [4];
    logic [19:0] prev, mid;
    int lat, busy_n;
    bit to;
    vals = '{16'd0, 16'd65535, 16'd1234, 16'd9999};
    exps = '{20'h00000, 20'h65535, 20'h01234, 20'h09999};
    for (int i = 0; i < 4; i++) begin
      prev = BCD;
      run_one(vals[i], lat, busy_n, mid, to);
      total++; if (to || lat != 17) begin bad++; $display("FAIL fixed_latency[%0d] got=%0d want=17", i, lat); end
      total++; if (busy_n != 17) begin bad++; $display("FAIL fixed_busy_cycles[%0d] got=%0d want=17", i, busy_n); end
      total++; if (mid !== prev) begin bad++; $display("FAIL fixed_bcd_hold[%0d] got=%h want=%h", i, mid, prev); end
      total++; if (BCD !== exps[i]) begin bad++; $display("FAIL fixed_bcd[%0d] got=%h want=%h", i, BCD, exps[i]); end
      total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL fixed_busy_at_done[%0d] got=%b want=0", i, BUSY); end
      @(negedge CLK);
      total++; if (DONE !== 1'b0) begin bad++; $display("FAIL fixed_done_width[%0d] got=%b want=0", i, DONE); end
    end
  endtask

  task automatic test_held_start();
    int pulses;
    @(negedge CLK);
    BIN    = 16'd500;
    START  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (i == 4) BIN = 16'd7;
      if (DONE) pulses++;
    end
    START = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DONE) pulses++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL held_start_pulses got=%0d want=1", pulses); end
    total++; if (BCD !== ref_bcd(500)) begin bad++; $display("FAIL held_start_bcd got=%h want=%h", BCD, ref_bcd(500)); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge CLK);
    BIN   = 16'd300;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat   = 0;
    while (!DONE && lat <= 40) begin
      if (lat == 5) begin START = 1'b1; BIN = 16'd42; end
      if (lat == 6) START = 1'b0;
      @(negedge CLK);
      lat++;
    end
    total++; if (lat != 17) begin bad++; $display("FAIL ignored_latency got=%0d want=17", lat); end
    total++; if (BCD !== ref_bcd(300)) begin bad++; $display("FAIL ignored_bcd got=%h want=%h", BCD, ref_bcd(300)); end
    BIN   = 16'd8765;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    total++; if (DONE !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL b2b_accept got=done%b/busy%b want=done0/busy1", DONE, BUSY);
    end
    lat = 0;
    while (!DONE && lat <= 40) begin @(negedge CLK); lat++; end
    total++; if (lat != 17) begin bad++; $display("FAIL b2b_latency got=%0d want=17", lat); end
    total++; if (BCD !== ref_bcd(8765)) begin bad++; $display("FAIL b2b_bcd got=%h want=%h", BCD, ref_bcd(8765)); end
  endtask

  task automatic test_reset_mid();
    int pulses, busy_seen;
    @(negedge CLK);
    BIN   = 16'd4321;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    total++; if (BCD !== 20'h0) begin bad++; $display("FAIL midreset_bcd got=%h want=%h", BCD, 20'h0); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", DONE); end
    @(negedge CLK);
    RST_N     = 1'b1;
    pulses    = 0;
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (DONE) pulses++;
      if (BUSY) busy_seen++;
    end
    total++; if (pulses != 0 || busy_seen != 0) begin
      bad++; $display("FAIL midreset_quiet got=done%0d/busy%0d want=0/0", pulses, busy_seen);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [19:0] mid;
    int lat, busy_n;
    bit to;
    int unsigned a, b;
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) begin
        v = 16'($urandom);
      end else begin
        a = $urandom_range(0, 65535);
        b = $urandom_range(1, 300);
        v = 16'(a / b);
      end
      run_one(v, lat, busy_n, mid, to);
      total++; if (to || lat != 17 || BCD !== ref_bcd(32'(v))) begin
        bad++; $display("FAIL random[%0d] bin=%0d got=%h lat=%0d want=%h lat=17", i, v, BCD, lat, ref_bcd(32'(v)));
      end
    end
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    BIN   = '0;
    test_reset();
    test_fixed();
    test_held_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
